// File: rtl/id_ex_stage_pkg.sv
// Shared decode/execute definitions: write-register selects, ALU opcodes
// and the ID/EX stage state encoding.
package id_ex_stage_pkg;

  typedef enum logic [1:0] {
    WRREG_RT  = 2'd0,
    WRREG_RD  = 2'd1,
    WRREG_R31 = 2'd2,
    WRREG_NONE = 2'd3
  } wrreg_sel_e;

  localparam int unsigned ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_NOR  = 5'd5,
    ALU_SLT  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_SLL  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SRA  = 5'd10,
    ALU_LUI  = 5'd11
  } alu_op_e;

  typedef enum logic {
    STATE_RUN    = 1'b0,
    STATE_BUBBLE = 1'b1
  } stage_state_e;

endpackage

// File: rtl/id_ex_stage_sat_counter.sv
// Width-parameterised saturating incrementer; sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register (xREG2) with load-use bubble insertion,
// branch flush, data-memory freeze and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALUOP_W = ALU_OP_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               do_hazard,
  input  logic               do_flush,
  input  logic               dm_busy,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  f_reg_ra_data,
  input  logic [DATA_W-1:0]  f_reg_rb_data,
  input  logic [DATA_W-1:0]  f_reg_rt_data,
  input  logic [DATA_W-1:0]  id_imm_extend,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_do_dm_read,
  input  logic               id_do_dm_write,
  input  logic               id_do_reg_write,
  input  logic [1:0]         id_select_write_reg,
  input  logic [4:0]         id_write_reg_addr,
  output logic               xREG2_valid,
  output logic [DATA_W-1:0]  xREG2_pc,
  output logic [DATA_W-1:0]  xREG2_ra_data,
  output logic [DATA_W-1:0]  xREG2_rb_data,
  output logic [DATA_W-1:0]  xREG2_rt_data,
  output logic [DATA_W-1:0]  xREG2_imm_extend,
  output logic [ALUOP_W-1:0] xREG2_alu_op,
  output logic               xREG2_do_dm_read,
  output logic               xREG2_do_dm_write,
  output logic               xREG2_do_reg_write,
  output logic [1:0]         xREG2_select_write_reg,
  output logic [4:0]         xREG2_write_reg_addr,
  output logic               stall_pc,
  output logic               stall_ifid,
  output logic [CNT_W-1:0]   bubble_count
);

  stage_state_e state;
  logic         stall;
  logic         bubble_inc;

  // Gated by rst so the hold lines read 0 throughout reset.
  assign stall      = rst & (dm_busy | (do_hazard & ~do_flush));
  assign stall_pc   = stall;
  assign stall_ifid = stall;
  assign bubble_inc = ~dm_busy & ~do_flush & do_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= STATE_RUN;
      xREG2_valid            <= 1'b0;
      xREG2_pc               <= '0;
      xREG2_ra_data          <= '0;
      xREG2_rb_data          <= '0;
      xREG2_rt_data          <= '0;
      xREG2_imm_extend       <= '0;
      xREG2_alu_op           <= '0;
      xREG2_do_dm_read       <= 1'b0;
      xREG2_do_dm_write      <= 1'b0;
      xREG2_do_reg_write     <= 1'b0;
      xREG2_select_write_reg <= '0;
      xREG2_write_reg_addr   <= '0;
    end else if (dm_busy) begin
      state <= state;
    end else if (do_flush || do_hazard) begin
      // Bubble: data fields are left as-is, only validity and controls are killed.
      state                <= do_flush ? STATE_RUN : STATE_BUBBLE;
      xREG2_valid          <= 1'b0;
      xREG2_do_dm_read     <= 1'b0;
      xREG2_do_dm_write    <= 1'b0;
      xREG2_do_reg_write   <= 1'b0;
      xREG2_write_reg_addr <= '0;
    end else begin
      state                  <= STATE_RUN;
      xREG2_valid            <= id_valid;
      xREG2_pc               <= id_pc;
      xREG2_ra_data          <= f_reg_ra_data;
      xREG2_rb_data          <= f_reg_rb_data;
      xREG2_rt_data          <= f_reg_rt_data;
      xREG2_imm_extend       <= id_imm_extend;
      xREG2_alu_op           <= id_alu_op;
      xREG2_do_dm_read       <= id_do_dm_read & id_valid;
      xREG2_do_dm_write      <= id_do_dm_write & id_valid;
      xREG2_do_reg_write     <= id_do_reg_write & id_valid;
      xREG2_select_write_reg <= id_select_write_reg;
      xREG2_write_reg_addr   <= id_write_reg_addr;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (bubble_inc),
    .count (bubble_count)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random
// traffic against a transaction-level model of the stage.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          do_hazard = 1'b0, do_flush = 1'b0, dm_busy = 1'b0;
  logic          id_valid = 1'b0;
  logic [DW-1:0] id_pc = '0, f_reg_ra_data = '0, f_reg_rb_data = '0;
  logic [DW-1:0] f_reg_rt_data = '0, id_imm_extend = '0;
  logic [AW-1:0] id_alu_op = '0;
  logic          id_do_dm_read = 1'b0, id_do_dm_write = 1'b0, id_do_reg_write = 1'b0;
  logic [1:0]    id_select_write_reg = '0;
  logic [4:0]    id_write_reg_addr = '0;

  logic          xREG2_valid;
  logic [DW-1:0] xREG2_pc, xREG2_ra_data, xREG2_rb_data, xREG2_rt_data, xREG2_imm_extend;
  logic [AW-1:0] xREG2_alu_op;
  logic          xREG2_do_dm_read, xREG2_do_dm_write, xREG2_do_reg_write;
  logic [1:0]    xREG2_select_write_reg;
  logic [4:0]    xREG2_write_reg_addr;
  logic          stall_pc, stall_ifid;
  logic [CW-1:0] bubble_count;

  id_ex_stage #(.DATA_W(DW), .ALUOP_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .do_hazard(do_hazard), .do_flush(do_flush), .dm_busy(dm_busy),
    .id_valid(id_valid), .id_pc(id_pc), .f_reg_ra_data(f_reg_ra_data),
    .f_reg_rb_data(f_reg_rb_data), .f_reg_rt_data(f_reg_rt_data),
    .id_imm_extend(id_imm_extend), .id_alu_op(id_alu_op),
    .id_do_dm_read(id_do_dm_read), .id_do_dm_write(id_do_dm_write),
    .id_do_reg_write(id_do_reg_write), .id_select_write_reg(id_select_write_reg),
    .id_write_reg_addr(id_write_reg_addr),
    .xREG2_valid(xREG2_valid), .xREG2_pc(xREG2_pc), .xREG2_ra_data(xREG2_ra_data),
    .xREG2_rb_data(xREG2_rb_data), .xREG2_rt_data(xREG2_rt_data),
    .xREG2_imm_extend(xREG2_imm_extend), .xREG2_alu_op(xREG2_alu_op),
    .xREG2_do_dm_read(xREG2_do_dm_read), .xREG2_do_dm_write(xREG2_do_dm_write),
    .xREG2_do_reg_write(xREG2_do_reg_write),
    .xREG2_select_write_reg(xREG2_select_write_reg),
    .xREG2_write_reg_addr(xREG2_write_reg_addr),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what execute should be holding.
  logic          m_valid, m_rd, m_wr, m_rw, m_def;
  logic [DW-1:0] m_pc, m_ra, m_rb, m_rt, m_imm;
  logic [AW-1:0] m_alu;
  logic [1:0]    m_sel;
  logic [4:0]    m_addr;
  int            m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_def = 1;
    m_pc = '0; m_ra = '0; m_rb = '0; m_rt = '0; m_imm = '0;
    m_alu = '0; m_sel = '0; m_addr = '0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (dm_busy) begin
      // frozen
    end else if (do_flush || do_hazard) begin
      m_valid = 0; m_rd = 0; m_wr = 0; m_rw = 0; m_addr = '0; m_def = 0;
      if (!do_flush && m_cnt < 15) m_cnt++;
    end else begin
      m_valid = id_valid;
      m_pc = id_pc; m_ra = f_reg_ra_data; m_rb = f_reg_rb_data; m_rt = f_reg_rt_data;
      m_imm = id_imm_extend; m_alu = id_alu_op; m_sel = id_select_write_reg;
      m_addr = id_write_reg_addr;
      m_rd = id_valid & id_do_dm_read;
      m_wr = id_valid & id_do_dm_write;
      m_rw = id_valid & id_do_reg_write;
      m_def = 1;
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".valid"}, 32'(xREG2_valid), 32'(m_valid));
    chk({tag, ".dm_read"}, 32'(xREG2_do_dm_read), 32'(m_rd));
    chk({tag, ".dm_write"}, 32'(xREG2_do_dm_write), 32'(m_wr));
    chk({tag, ".reg_write"}, 32'(xREG2_do_reg_write), 32'(m_rw));
    chk({tag, ".wr_addr"}, 32'(xREG2_write_reg_addr), 32'(m_addr));
    chk({tag, ".bubble_count"}, 32'(bubble_count), 32'(m_cnt));
    if (m_def) begin
      chk({tag, ".pc"}, xREG2_pc, m_pc);
      chk({tag, ".ra"}, xREG2_ra_data, m_ra);
      chk({tag, ".rb"}, xREG2_rb_data, m_rb);
      chk({tag, ".rt"}, xREG2_rt_data, m_rt);
      chk({tag, ".imm"}, xREG2_imm_extend, m_imm);
      chk({tag, ".alu_op"}, 32'(xREG2_alu_op), 32'(m_alu));
      chk({tag, ".sel"}, 32'(xREG2_select_write_reg), 32'(m_sel));
    end
  endtask

  // Check the combinational hold lines, advance one edge, check the register.
  task automatic step(input string tag);
    logic exp_stall;
    #1;
    exp_stall = rst && (dm_busy || (do_hazard && !do_flush));
    chk({tag, ".stall_pc"}, 32'(stall_pc), 32'(exp_stall));
    chk({tag, ".stall_ifid"}, 32'(stall_ifid), 32'(exp_stall));
    model_edge();
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic rand_id();
    id_valid = 1'($urandom);
    id_pc = $urandom; f_reg_ra_data = $urandom; f_reg_rb_data = $urandom;
    f_reg_rt_data = $urandom; id_imm_extend = $urandom;
    id_alu_op = AW'($urandom); id_select_write_reg = 2'($urandom);
    id_write_reg_addr = 5'($urandom);
    id_do_dm_read = 1'($urandom); id_do_dm_write = 1'($urandom);
    id_do_reg_write = 1'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(xREG2_valid), 0);
    chk({tag, ".pc"}, xREG2_pc, 0);
    chk({tag, ".ra"}, xREG2_ra_data, 0);
    chk({tag, ".rb"}, xREG2_rb_data, 0);
    chk({tag, ".rt"}, xREG2_rt_data, 0);
    chk({tag, ".imm"}, xREG2_imm_extend, 0);
    chk({tag, ".alu_op"}, 32'(xREG2_alu_op), 0);
    chk({tag, ".ctrl"}, {29'd0, xREG2_do_dm_read, xREG2_do_dm_write, xREG2_do_reg_write}, 0);
    chk({tag, ".sel"}, 32'(xREG2_select_write_reg), 0);
    chk({tag, ".wr_addr"}, 32'(xREG2_write_reg_addr), 0);
    chk({tag, ".bubble_count"}, 32'(bubble_count), 0);
    chk({tag, ".stall_pc"}, 32'(stall_pc), 0);
    chk({tag, ".stall_ifid"}, 32'(stall_ifid), 0);
  endtask

  initial begin
    logic [DW-1:0] frz_pc;

    // Reset state, with dm_busy high to show the hold lines stay low.
    model_reset();
    dm_busy = 1'b1;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    dm_busy = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Normal flow: add r3.
    id_valid = 1; id_pc = 32'h100; f_reg_ra_data = 32'h10; f_reg_rb_data = 32'h22;
    f_reg_rt_data = 32'h33; id_imm_extend = 32'h4; id_alu_op = ALU_ADD;
    id_do_reg_write = 1; id_do_dm_read = 0; id_do_dm_write = 0;
    id_select_write_reg = WRREG_RD; id_write_reg_addr = 5'd3;
    step("normal");

    // Load-use: one hazard cycle, then the held instruction is captured.
    id_pc = 32'h104; f_reg_ra_data = 32'h55; id_write_reg_addr = 5'd7;
    do_hazard = 1;
    step("loaduse.bubble");
    do_hazard = 0;
    step("loaduse.capture");

    // Flush and hazard together: flush wins, no count.
    id_pc = 32'h108; id_do_dm_read = 1; id_write_reg_addr = 5'd9;
    do_flush = 1; do_hazard = 1;
    step("flush_hazard");
    do_flush = 0; do_hazard = 0;
    step("after_flush");

    // Freeze for three cycles with changing decode inputs.
    frz_pc = xREG2_pc;
    dm_busy = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step("freeze");
      chk("freeze.pc_const", xREG2_pc, frz_pc);
    end
    dm_busy = 0;
    rand_id();
    step("unfreeze");

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      rand_id();
      do_hazard = ($urandom_range(0, 5) == 0);
      do_flush  = ($urandom_range(0, 7) == 0);
      dm_busy   = ($urandom_range(0, 7) == 0);
      step("random");
    end
    do_hazard = 0; do_flush = 0; dm_busy = 0;

    // Saturation: restart from reset and force 17 hazard cycles.
    #2;
    rst = 0;
    model_reset();
    #1;
    check_all_zero("reset2");
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    do_hazard = 1;
    for (int i = 0; i < 17; i++) begin
      rand_id();
      step("saturate");
    end
    chk("saturate.final", 32'(bubble_count), 15);
    do_hazard = 0;

    // Reset mid-operation with a valid load held in the stage.
    id_valid = 1; id_do_dm_read = 1; id_do_reg_write = 1; id_write_reg_addr = 5'd12;
    id_pc = 32'hABC0; f_reg_ra_data = 32'h1234;
    step("load_fill");
    dm_busy = 1;
    step("load_hold");
    #2;
    rst = 0;
    model_reset();
    #1;
    check_all_zero("reset_mid");
    dm_busy = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register (the xREG2 stage) with load-use bubble insertion, branch flush and whole-pipe freeze.
- Captures the forwarded operands and decode controls every cycle and presents them to execute and to the forwarding network as xREG2_* signals.
- Raises the IF/ID hold signals when a load-use hazard is flagged.
- Keeps a saturating count of bubble cycles for performance monitoring.

Parameters:
- DATA_W, 32, operand/immediate/PC width.
- ALUOP_W, 5, ALU opcode width.
- CNT_W, 16, bubble counter width.

Ports:
- clk  input  1  stage clock.
- rst  input  1  asynchronous active-low reset.
- do_hazard  input  1  load-use hazard flag from the forwarding unit.
- do_flush  input  1  branch/jump taken in execute; kill the instruction in decode.
- dm_busy  input  1  data memory multi-cycle stall; freeze the stage.
- id_valid  input  1  decode holds a real instruction.
- id_pc  input  DATA_W  PC of the decode instruction.
- f_reg_ra_data, f_reg_rb_data, f_reg_rt_data  input  DATA_W each  forwarded operands.
- id_imm_extend  input  DATA_W  extended immediate.
- id_alu_op  input  ALUOP_W  ALU opcode.
- id_do_dm_read, id_do_dm_write, id_do_reg_write  input  1 each  decode controls.
- id_select_write_reg  input  2  WRREG_* select.
- id_write_reg_addr  input  5  destination register.
- xREG2_valid  output  1  execute holds a real instruction.
- xREG2_pc, xREG2_ra_data, xREG2_rb_data, xREG2_rt_data, xREG2_imm_extend  output  DATA_W each  registered copies.
- xREG2_alu_op  output  ALUOP_W  registered opcode.
- xREG2_do_dm_read, xREG2_do_dm_write, xREG2_do_reg_write  output  1 each  registered controls, gated by valid.
- xREG2_select_write_reg  output  2  registered select.
- xREG2_write_reg_addr  output  5  registered destination.
- stall_pc  output  1  hold PC this cycle.
- stall_ifid  output  1  hold the IF/ID register this cycle.
- bubble_count  output  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset (rst=0, asynchronous): all xREG2_* outputs 0, xREG2_valid=0, state=RUN, bubble_count=0.
- stall_pc and stall_ifid are combinational and therefore also 0 while in reset.
- State machine, two states:
  - RUN: normal capture.
  - BUBBLE: one cycle after a bubble is inserted.
- Priority on each rising edge, highest first:
  1. dm_busy=1: hold every register and the state. stall_pc=stall_ifid=1. No count.
  2. do_flush=1: load a bubble; state=RUN. Flush wins over hazard. stall_pc=stall_ifid=0.
  3. do_hazard=1: load a bubble; state=BUBBLE; bubble_count+1, saturating at all-ones. stall_pc=stall_ifid=1 in the same cycle.
  4. Otherwise: capture all id_* values. xREG2_valid=id_valid. state=RUN.
- Bubble definition:
  - xREG2_valid=0 and all three do_* controls 0.
  - xREG2_write_reg_addr=0.
  - Data fields keep their previous values; do not care.
- Controls are never asserted while valid=0. Capture ANDs id_do_* with id_valid.
- Latency: 1 cycle from decode to xREG2_* outputs.
- The hazard clears naturally once the load advances. If do_hazard is still 1 in BUBBLE state, that is a protocol error: insert a further bubble and count it (no lock-up).
- A flush during BUBBLE returns the state to RUN.
- dm_busy during BUBBLE holds the BUBBLE state.
- stall_pc = stall_ifid = dm_busy | (do_hazard & ~do_flush).

Decomposition:
- Shared package/define file (alongside def_muxs.v) holds:
  - WRREG_* select codes;
  - ALU opcode width and codes;
  - STATE_RUN / STATE_BUBBLE encodings.
- Sub-module: sat_counter (width-parameterised saturating incrementer with async active-low reset). It is reused for bubble_count and other performance counters.

Test Plan:
- Reset mid-operation: hold the stage full with valid load data, drive rst=0 asynchronously between edges. All xREG2_* must read 0 immediately and bubble_count=0.
- Normal flow: id_valid=1, add r3 (id_write_reg_addr=3, id_do_reg_write=1, f_reg_ra_data=0x10). Next edge: xREG2_valid=1, xREG2_write_reg_addr=3, xREG2_ra_data=0x10. stall_pc=0.
- Load-use: do_hazard=1 for one cycle. Required:
  - stall_pc=stall_ifid=1 that cycle;
  - next cycle xREG2_valid=0 with all do_* 0;
  - bubble_count=1;
  - the following cycle captures the held instruction.
- Flush vs hazard: do_flush=1 and do_hazard=1 together. Required: bubble loaded, stall_pc=0, bubble_count unchanged, state=RUN.
- Freeze: dm_busy=1 for 3 cycles with id_* changing. xREG2_* stay constant, stall_pc=1 throughout; capture resumes on the first edge after dm_busy falls.
- Saturation: with CNT_W=4, force 17 hazard cycles. Required: bubble_count=15 and no wrap to 0.
